// File: rtl/vga_marker_overlay.sv
// vga_marker_overlay: programmable VGA raster timing with delayed pixel alignment and an N-channel marker overlay.
module vga_marker_overlay #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 11,
  parameter int V_SYNC = 2,
  parameter int V_BP = 31,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DELAY = 2,
  parameter int N_MARKERS = 4,
  parameter int CROSS_R = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_MARKERS*HW-1:0] marker_x,
  input  logic [N_MARKERS*VW-1:0] marker_y,
  input  logic [N_MARKERS-1:0]    marker_en,
  input  logic [N_MARKERS-1:0]    marker_mode,
  input  logic [N_MARKERS*24-1:0] marker_color,
  input  logic [23:0]             pixel_rgb,
  output logic [HW-1:0]           hcount,
  output logic [VW-1:0]           vcount,
  output logic                    pixel_req,
  output logic                    frame_start,
  output logic [7:0]              vga_red,
  output logic [7:0]              vga_green,
  output logic [7:0]              vga_blue,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_blank_b
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam logic SP = 1'(SYNC_POL);
  localparam logic signed [HW:0] RX = (HW+1)'(CROSS_R);
  localparam logic signed [VW:0] RY = (VW+1)'(CROSS_R);
  typedef struct packed {
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          hs;
    logic          vs;
    logic          bl;
  } tap_t;
  logic h_last, v_last, hs_raw, vs_raw, bl_raw;
  tap_t dl [PIPE_DELAY];
  logic [HW-1:0] dx;
  logic [VW-1:0] dy;
  logic [N_MARKERS*HW-1:0] sx;
  logic [N_MARKERS*VW-1:0] sy;
  logic [N_MARKERS-1:0] sen, smode, hit, hit1;
  logic [N_MARKERS*24-1:0] scol;
  logic [23:0] rgb1, col;
  logic hs1, vs1, bl1;
  assign h_last = hcount == HW'(H_TOTAL - 1);
  assign v_last = vcount == VW'(V_TOTAL - 1);
  assign hs_raw = hcount >= HW'(HS_BEG) && hcount < HW'(HS_BEG + H_SYNC);
  assign vs_raw = vcount >= VW'(VS_BEG) && vcount < VW'(VS_BEG + V_SYNC);
  assign bl_raw = hcount >= HW'(H_ACTIVE) || vcount >= VW'(V_ACTIVE);
  assign pixel_req = ~bl_raw & ~reset;
  assign frame_start = hcount == '0 && vcount == '0 && !reset;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_last ? '0 : hcount + 1'b1;
      if (h_last) vcount <= v_last ? '0 : vcount + 1'b1;
    end
  // Blank taps reset high so no stale colour escapes before real data arrives.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int k = 0; k < PIPE_DELAY; k++) dl[k] <= '{h: '0, v: '0, hs: 1'b0, vs: 1'b0, bl: 1'b1};
    end else begin
      dl[0] <= '{h: hcount, v: vcount, hs: hs_raw, vs: vs_raw, bl: bl_raw};
      for (int k = 1; k < PIPE_DELAY; k++) dl[k] <= dl[k-1];
    end
  assign dx = dl[PIPE_DELAY-1].h;
  assign dy = dl[PIPE_DELAY-1].v;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sx <= '0;
      sy <= '0;
      sen <= '0;
      smode <= '0;
      scol <= '0;
    end else if (h_last && v_last) begin
      sx <= marker_x;
      sy <= marker_y;
      sen <= marker_en;
      smode <= marker_mode;
      scol <= marker_color;
    end
  genvar i;
  for (i = 0; i < N_MARKERS; i++) begin : g_hit
    logic signed [HW:0] ex;
    logic signed [VW:0] ey;
    logic on_x, on_y, near_x, near_y;
    assign ex = $signed({1'b0, dx}) - $signed({1'b0, sx[i*HW +: HW]});
    assign ey = $signed({1'b0, dy}) - $signed({1'b0, sy[i*VW +: VW]});
    assign on_x = ex == '0;
    assign on_y = ey == '0;
    assign near_x = ex >= -RX && ex <= RX;
    assign near_y = ey >= -RY && ey <= RY;
    assign hit[i] = sen[i] & (smode[i] ? (on_y & near_x) | (on_x & near_y) : on_x | on_y);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hit1 <= '0;
      rgb1 <= '0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      bl1 <= 1'b1;
    end else begin
      hit1 <= hit;
      rgb1 <= pixel_rgb;
      hs1 <= dl[PIPE_DELAY-1].hs;
      vs1 <= dl[PIPE_DELAY-1].vs;
      bl1 <= dl[PIPE_DELAY-1].bl;
    end
  // Descending scan so the lowest-index hit wins.
  always_comb begin
    col = rgb1;
    for (int k = N_MARKERS - 1; k >= 0; k--) col = hit1[k] ? scol[k*24 +: 24] : col;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {vga_red, vga_green, vga_blue} <= '0;
      vga_hsync <= ~SP;
      vga_vsync <= ~SP;
      vga_blank_b <= 1'b0;
    end else begin
      {vga_red, vga_green, vga_blue} <= bl1 ? 24'h0 : col;
      vga_hsync <= hs1 ? SP : ~SP;
      vga_vsync <= vs1 ? SP : ~SP;
      vga_blank_b <= ~bl1;
    end
endmodule

// File: doc/vga_marker_overlay.md
Name: vga_marker_overlay

Overview:
Parametrised VGA raster engine with an N-channel marker overlay. It generates programmable sync, blank and count timing, and issues per-pixel fetch coordinates for the frame-buffer read path. It aligns returning pixel data by a configurable pipeline delay and composites up to N_MARKERS coloured crosshair or cross-cursor markers over the video. It sits between the memory read interface and the VGA DAC pins, replacing fixed 640x480 timing and fixed four-crosshair overlays.

Parameters:
HW, 10, width of hcount and all x coordinates
VW, 10, width of vcount and all y coordinates
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 11, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 31, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active low)
PIPE_DELAY, 2, cycles from coordinate output to pixel_rgb valid (minimum 1)
N_MARKERS, 4, number of overlay channels (1..8)
CROSS_R, 8, half-arm length in pixels for mode-1 markers

Ports:
clock  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high
marker_x  in  N_MARKERS*HW  packed marker x, channel i at [i*HW +: HW]
marker_y  in  N_MARKERS*VW  packed marker y
marker_en  in  N_MARKERS  per-channel enable
marker_mode  in  N_MARKERS  0 = full-screen crosshair, 1 = cross of arm CROSS_R
marker_color  in  N_MARKERS*24  packed {R,G,B} per channel
pixel_rgb  in  24  {R,G,B} for the coordinates issued PIPE_DELAY cycles earlier
hcount  out  HW  current raster x (undelayed; fetch address)
vcount  out  VW  current raster y (undelayed)
pixel_req  out  1  high when (hcount,vcount) is in the active area
frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
vga_red, vga_green, vga_blue  out  8 each  composited colour
vga_hsync, vga_vsync  out  1 each  syncs, aligned to colour
vga_blank_b  out  1  low during blanking, aligned to colour

Behaviour:
- Reset (async, any time): hcount=0, vcount=0; pixel_req=0; frame_start=0; RGB=0; blank_b=0; syncs at the inactive level (~SYNC_POL); delay lines cleared; shadow marker registers cleared (all disabled). Counting resumes on the first edge after deassert from (0,0).
- H_TOTAL = sum of the H parameters, V_TOTAL = sum of the V parameters. hcount wraps H_TOTAL-1 -> 0. vcount increments only on the hcount wrap and wraps V_TOTAL-1 -> 0.
- Raw hsync is active when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Raw vsync uses the same rule on vcount.
- Raw blank = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE). pixel_req = ~raw blank, combinational from the count registers.
- Pipeline: hcount, vcount, raw syncs and raw blank pass through a PIPE_DELAY-stage shift register, giving the delayed coordinates (dx,dy). pixel_rgb is sampled with them.
- Marker hit for channel i (stage 1, registered):
  - en_i and one of:
    - mode 0: dx==x_i or dy==y_i
    - mode 1: (dy==y_i and |dx-x_i|<=CROSS_R) or (dx==x_i and |dy-y_i|<=CROSS_R)
  - Differences are computed signed, one bit wider than the operands; no wrap-around of arms across screen edges.
- Output register (stage 2):
  - blank -> RGB 0
  - else the lowest-index hit channel's colour
  - else pixel_rgb delayed one cycle to match the hit stage
- Syncs and blank_b are registered in the same stage. Total latency from count to pins is PIPE_DELAY+2 cycles for every output signal.
- Shadowing:
  - marker_* inputs are copied to shadow registers only on the cycle hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - Mid-frame input changes have no visible effect until the next frame.
  - The first frame after reset shows no markers.
- Markers with coordinates outside the active area draw only the in-range portion. A mode-0 marker with x >= H_ACTIVE draws only its horizontal line.

Test Plan:
- Reset asserted mid-line for 3 cycles -> outputs go to reset values asynchronously (before the next edge). After deassert, hcount is 0 then 1, 2, …; first frame_start one cycle after deassert edge.
- Default params, free run 2 frames -> line period 800 clocks, frame 419200 clocks. vga_hsync low for 96 cycles starting 4 cycles after hcount=656. vsync low for exactly 2 lines from vcount=491. blank_b high 640 cycles per active line.
- PIPE_DELAY=2, model returns pixel_rgb = {hcount[7:0], vcount[7:0], 8'h5A} for issued coordinates -> pin colour at active pixel (x,y) equals that value, 4 cycles after issue, for every pixel.
- Channels 0 and 2 enabled, mode 0, both at (100,50), colours FF00FF and 00FFFF -> row 50 and column 100 show FF00FF (channel 0 priority); other pixels show video.
- Channel 1, mode 1, at (5,5), CROSS_R=8 -> row 5 coloured for x 0..13 only, column 5 for y 0..13 only; no pixels at x≥634 (no wrap).
- marker_x changed at line 200 of frame k -> frame k unchanged; new position appears from frame k+1 line 0.
